// File: rtl/seg7_scan_reader.sv
// Rebuilds the value shown on a multiplexed 4-digit common-anode 7-segment bus.
// Each digit is captured once it has dwelt unchanged long enough; four digits make a frame.
module seg7_scan_reader #(
    parameter int unsigned STABLE_CYC = 4,
    parameter int unsigned CNT_W      = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  an,
    input  logic [7:0]  seg,
    output logic [15:0] value,
    output logic [3:0]  points,
    output logic [3:0]  blank,
    output logic [3:0]  err,
    output logic        frame_valid
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYC - 1);

    logic [3:0]       an_q, an_p;
    logic [7:0]       seg_q, seg_p;
    logic [CNT_W-1:0] cnt_q;
    logic             captured_q;
    logic [3:0]       seen_q;
    logic             complete_q;
    logic [15:0]      sh_val;
    logic [3:0]       sh_pt, sh_bl, sh_er;

    logic             changed, onehot, capture;
    logic [1:0]       idx;
    logic [3:0]       sel, seen_nxt;
    logic [5:0]       dec;

    // Returns {blank, err, nibble} for a lit mask in gfedcba order.
    function automatic logic [5:0] decode(input logic [6:0] lit);
        logic [5:0] r;
        unique case (lit)
            7'h3F:   r = 6'h00;
            7'h06:   r = 6'h01;
            7'h5B:   r = 6'h02;
            7'h4F:   r = 6'h03;
            7'h66:   r = 6'h04;
            7'h6D:   r = 6'h05;
            7'h7D:   r = 6'h06;
            7'h07:   r = 6'h07;
            7'h7F:   r = 6'h08;
            7'h6F:   r = 6'h09;
            7'h77:   r = 6'h0A;
            7'h7C:   r = 6'h0B;
            7'h39:   r = 6'h0C;
            7'h5E:   r = 6'h0D;
            7'h79:   r = 6'h0E;
            7'h71:   r = 6'h0F;
            7'h00:   r = 6'b10_0000;
            default: r = 6'b01_0000;
        endcase
        return r;
    endfunction

    always_comb begin
        onehot = 1'b1;
        idx    = 2'd0;
        unique case (an_q)
            4'b1110: idx = 2'd0;
            4'b1101: idx = 2'd1;
            4'b1011: idx = 2'd2;
            4'b0111: idx = 2'd3;
            default: onehot = 1'b0;
        endcase
        sel      = 4'b0001 << idx;
        changed  = {an_q, seg_q} != {an_p, seg_p};
        capture  = !changed && onehot && (cnt_q == CNT_MAX) && !captured_q;
        dec      = decode(~seg_q[6:0]);
        // A completion copy clears seen; a capture in that same cycle starts the new frame.
        seen_nxt = (complete_q ? 4'h0 : seen_q) | (capture ? sel : 4'h0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an_q  <= 4'hF;
            seg_q <= 8'hFF;
            an_p  <= 4'hF;
            seg_p <= 8'hFF;
        end else begin
            an_q  <= an;
            seg_q <= seg;
            an_p  <= an_q;
            seg_p <= seg_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q      <= '0;
            captured_q <= 1'b0;
        end else if (changed || !onehot) begin
            cnt_q      <= '0;
            captured_q <= 1'b0;
        end else begin
            if (cnt_q != CNT_MAX) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
            if (capture) begin
                captured_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seen_q     <= 4'h0;
            complete_q <= 1'b0;
            sh_val     <= 16'h0000;
            sh_pt      <= 4'h0;
            sh_bl      <= 4'hF;
            sh_er      <= 4'h0;
        end else begin
            seen_q     <= seen_nxt;
            complete_q <= capture && (seen_nxt == 4'hF);
            if (capture) begin
                sh_val[{idx, 2'b00} +: 4] <= dec[3:0];
                sh_pt[idx]                <= ~seg_q[7];
                sh_bl[idx]                <= dec[5];
                sh_er[idx]                <= dec[4];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value       <= 16'h0000;
            points      <= 4'h0;
            blank       <= 4'hF;
            err         <= 4'h0;
            frame_valid <= 1'b0;
        end else begin
            frame_valid <= complete_q;
            if (complete_q) begin
                value  <= sh_val;
                points <= sh_pt;
                blank  <= sh_bl;
                err    <= sh_er;
            end
        end
    end

endmodule
